// File: rtl/decode_pkg.sv
// Shared RV32 decode definitions: instruction format codes, base opcodes
// and the opcode-to-format classifier used by the decode stage.
package decode_pkg;

  typedef enum logic [2:0] {
    FMT_I       = 3'b000,
    FMT_U       = 3'b001,
    FMT_S       = 3'b010,
    FMT_R       = 3'b011,
    FMT_ILLEGAL = 3'b100,
    FMT_SB      = 3'b110,
    FMT_UJ      = 3'b111
  } fmt_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  function automatic fmt_t opcode_format(input logic [6:0] op);
    fmt_t f;
    case (op)
      OP_OP:                                  f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:    f = FMT_I;
      OP_STORE:                               f = FMT_S;
      OP_BRANCH:                              f = FMT_SB;
      OP_LUI, OP_AUIPC:                       f = FMT_U;
      OP_JAL:                                 f = FMT_UJ;
      default:                                f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational RV32 word decode: raw field slices, format code and the
// sign-extended immediate for that format.
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic [2:0]  tipo
);

  fmt_t fmt;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign fmt  = opcode_format(instr[6:0]);
  assign tipo = fmt;

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:  imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_SB: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:  imm = {instr[31:12], 12'b0};
      FMT_UJ: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: first-word fall-through instruction FIFO with combinational
// decode of the head entry. Define DECODE_STATS_EN for per-format pop counters.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [6:0]               opcode,
  output logic [4:0]               rd,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [2:0]               funct3,
  output logic [6:0]               funct7,
  output logic [31:0]              imm,
  output logic [2:0]               tipo,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     illegal_seen
`ifdef DECODE_STATS_EN
  ,
  output logic [CNT_W-1:0]         cnt_r,
  output logic [CNT_W-1:0]         cnt_i,
  output logic [CNT_W-1:0]         cnt_s,
  output logic [CNT_W-1:0]         cnt_sb,
  output logic [CNT_W-1:0]         cnt_u,
  output logic [CNT_W-1:0]         cnt_uj,
  output logic [CNT_W-1:0]         cnt_ill
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic          push;
  logic          pop;

  logic [6:0]  d_opcode;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [2:0]  d_funct3;
  logic [6:0]  d_funct7;
  logic [31:0] d_imm;
  logic [2:0]  d_tipo;
  fmt_t        head_fmt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count != OW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = count;

  // Storage carries no reset: stale words are hidden while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end

  instr_field_decode u_field_decode (
    .instr  (mem[rd_ptr]),
    .opcode (d_opcode),
    .rd     (d_rd),
    .rs1    (d_rs1),
    .rs2    (d_rs2),
    .funct3 (d_funct3),
    .funct7 (d_funct7),
    .imm    (d_imm),
    .tipo   (d_tipo)
  );

  assign head_fmt = fmt_t'(d_tipo);

  always_comb begin
    opcode = '0;
    rd     = '0;
    rs1    = '0;
    rs2    = '0;
    funct3 = '0;
    funct7 = '0;
    imm    = '0;
    tipo   = FMT_ILLEGAL;
    if (out_valid) begin
      opcode = d_opcode;
      rd     = d_rd;
      rs1    = d_rs1;
      rs2    = d_rs2;
      funct3 = d_funct3;
      funct7 = d_funct7;
      imm    = d_imm;
      tipo   = d_tipo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 illegal_seen <= 1'b0;
    else if (pop && head_fmt == FMT_ILLEGAL)   illegal_seen <= 1'b1;
  end

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      cnt_i   <= '0;
      cnt_s   <= '0;
      cnt_sb  <= '0;
      cnt_u   <= '0;
      cnt_uj  <= '0;
      cnt_ill <= '0;
    end else if (pop) begin
      case (head_fmt)
        FMT_R:       if (cnt_r   != '1) cnt_r   <= cnt_r   + CNT_W'(1);
        FMT_I:       if (cnt_i   != '1) cnt_i   <= cnt_i   + CNT_W'(1);
        FMT_S:       if (cnt_s   != '1) cnt_s   <= cnt_s   + CNT_W'(1);
        FMT_SB:      if (cnt_sb  != '1) cnt_sb  <= cnt_sb  + CNT_W'(1);
        FMT_U:       if (cnt_u   != '1) cnt_u   <= cnt_u   + CNT_W'(1);
        FMT_UJ:      if (cnt_uj  != '1) cnt_uj  <= cnt_uj  + CNT_W'(1);
        FMT_ILLEGAL: if (cnt_ill != '1) cnt_ill <= cnt_ill + CNT_W'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule
